spi_xfer_arb: RTL and testbench
===============================

SPI_XFER_ARB -- requirements
Module: spi_xfer_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one SPI transfer engine (2..8).
REQ-002 SHALL have parameter CMD_W, default 32, width of one transfer command word.
REQ-003 SHALL have parameter TO_W, default 16, width of the timeout counter and limit.
REQ-004 SHALL have ports: clk_i in 1, single clock; rst_i in 1, reset, asynchronous active-high.
REQ-005 SHALL have ports: req_i in NUM_REQ, per-requester transfer request; cmd_i in NUM_REQ*CMD_W, flat command words, requester k at [k*CMD_W +: CMD_W].
REQ-006 SHALL have ports: gnt_o out NUM_REQ, grant pulse; done_o out NUM_REQ, completion pulse; err_o out NUM_REQ, timeout error pulse.
REQ-007 SHALL have ports: xfer_valid_o out 1, command offer to engine; xfer_ready_i in 1, engine accepts; xfer_cmd_o out CMD_W, latched command; xfer_done_i in 1, engine transfer finished.
REQ-008 SHALL have ports: abort_o out 1, engine abort pulse; cs_idx_o out $clog2(NUM_REQ), chip-select index of owner; busy_o out 1, not IDLE; timeout_cyc_i in TO_W, timeout limit in cycles, 0 = disabled.

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE, ABORT.
REQ-010 In IDLE with any req_i set, SHALL pick a winner round-robin starting at pointer rr_ptr, assert gnt_o[winner] for that one cycle, latch cmd_i word and winner index, and enter ISSUE next cycle.
REQ-011 Requesters SHALL hold req_i and cmd_i until gnt_o; a request dropped before grant SHALL have no effect.
REQ-012 In ISSUE, SHALL drive xfer_valid_o=1 and xfer_cmd_o=latched word, stable until xfer_ready_i=1; the cycle xfer_ready_i=1 SHALL transition to WAIT.
REQ-013 In WAIT, xfer_done_i=1 SHALL transition to DONE; xfer_done_i in any other state SHALL be ignored.
REQ-014 In DONE, SHALL pulse done_o[owner] one cycle, set rr_ptr = owner+1 with wrap NUM_REQ-1 -> 0, and return to IDLE.
REQ-015 Minimum latency grant-to-next-grant SHALL be 4 cycles (IDLE, ISSUE with ready, WAIT with done, DONE).
REQ-016 cs_idx_o SHALL equal latched owner in ISSUE/WAIT/DONE/ABORT and hold its last value in IDLE.
REQ-017 busy_o SHALL be 1 in every state except IDLE; gnt_o/done_o/err_o SHALL be one-hot or zero.
REQ-018 All requesters asserting simultaneously SHALL be served in order rr_ptr, rr_ptr+1, ... with no requester starved.

Reset
REQ-019 rst_i SHALL asynchronously force IDLE, rr_ptr=0, owner=0, and all outputs to 0, including mid-transfer; no done_o or err_o pulse SHALL be issued for the interrupted transfer.

Configuration
REQ-020 With macro SPI_ARB_TIMEOUT_EN defined, a TO_W counter SHALL clear on WAIT entry, increment each WAIT cycle, and when timeout_cyc_i!=0 and count reaches timeout_cyc_i enter ABORT.
REQ-021 ABORT SHALL pulse abort_o, err_o[owner] and done_o[owner] for one cycle, update rr_ptr as in DONE, and return to IDLE.
REQ-022 xfer_done_i and timeout in the same cycle SHALL take DONE (no error).
REQ-023 Without SPI_ARB_TIMEOUT_EN, no counter SHALL exist, ABORT SHALL be unreachable, abort_o and err_o SHALL be tied 0, and WAIT SHALL last until xfer_done_i.

Structure
REQ-024 Package spi_arb_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-025 Round-robin selection SHALL be sub-module spi_rr_arb (inputs req vector, pointer; outputs one-hot grant, index, any-valid), purely combinational.

Verification
REQ-026 Single request: req_i=4'b0100, cmd=32'hA5A5_0001, ready and done one cycle each -> gnt_o[2], xfer_cmd_o=32'hA5A5_0001, cs_idx_o=2, done_o[2] 4 cycles after grant.
REQ-027 All four request continuously from reset -> grants in order 0,1,2,3,0; each done_o before next gnt_o.
REQ-028 xfer_ready_i held low 10 cycles -> xfer_valid_o and xfer_cmd_o stable for all 10 cycles, WAIT entered on cycle 11.
REQ-029 SPI_ARB_TIMEOUT_EN, timeout_cyc_i=8, no xfer_done_i -> abort_o, err_o[owner], done_o[owner] pulse 8 WAIT cycles after entry; with timeout_cyc_i=0 no abort after 1000 cycles.
REQ-030 rst_i asserted during WAIT -> all outputs 0 immediately, no done_o pulse; after release, requester 0 granted first.
REQ-031 xfer_done_i pulsed in IDLE and ISSUE -> ignored, no done_o.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and default sizes for the SPI transfer arbiter.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } arb_state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_CMD_W   = 32;
    localparam int DEF_TO_W    = 16;

endpackage

// File: rtl/spi_xfer_arb_rr.sv
// Combinational round-robin picker: first active request at or after ptr_i, wrapping.
module spi_rr_arb
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               vld_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr_i < NUM_REQ and i < NUM_REQ, so one subtraction suffices for the wrap
            sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!vld_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                vld_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_xfer_arb.sv
// Round-robin arbiter sharing one SPI transfer engine among NUM_REQ requesters.
// Optional WAIT-state timeout with abort is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_xfer_arb
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int CMD_W   = DEF_CMD_W,
    parameter int TO_W    = DEF_TO_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*CMD_W-1:0]   cmd_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         done_o,
    output logic [NUM_REQ-1:0]         err_o,
    output logic                       xfer_valid_o,
    input  logic                       xfer_ready_i,
    output logic [CMD_W-1:0]           xfer_cmd_o,
    input  logic                       xfer_done_i,
    output logic                       abort_o,
    output logic [$clog2(NUM_REQ)-1:0] cs_idx_o,
    output logic                       busy_o,
    input  logic [TO_W-1:0]            timeout_cyc_i
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e         state_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   owner_q;
    logic [CMD_W-1:0]   cmd_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [CMD_W-1:0]   cmd_d;
    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_vld;

    spi_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i (req_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    always_comb begin
        cmd_d = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_gnt[k]) begin
                cmd_d = cmd_i[k*CMD_W +: CMD_W];
            end
        end
    end

    assign ptr_d    = (owner_q == IDX_W'(NUM_REQ-1)) ? '0 : owner_q + IDX_W'(1);
    assign owner_oh = NUM_REQ'(1) << owner_q;

`ifdef SPI_ARB_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q;
    logic            to_hit;

    // Fires in the last allowed WAIT cycle so ABORT starts exactly timeout_cyc_i cycles after entry
    assign to_hit = (timeout_cyc_i != '0) && ((to_cnt_q + TO_W'(1)) == timeout_cyc_i);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cmd_q    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_vld) begin
                        owner_q <= arb_idx;
                        cmd_q   <= cmd_d;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (xfer_ready_i) begin
                        state_q <= ST_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                        to_cnt_q <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (xfer_done_i) begin
                        state_q <= ST_DONE;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (to_hit) begin
                        state_q <= ST_ABORT;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
`endif
                end
                ST_DONE, ST_ABORT: begin
                    rr_ptr_q <= ptr_d;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Grant is a Mealy pulse in the IDLE cycle that picks the winner
    assign gnt_o        = (state_q == ST_IDLE && !rst_i) ? arb_gnt : '0;
    assign done_o       = (state_q == ST_DONE || state_q == ST_ABORT) ? owner_oh : '0;
    assign xfer_valid_o = (state_q == ST_ISSUE);
    assign xfer_cmd_o   = cmd_q;
    assign cs_idx_o     = owner_q;
    assign busy_o       = (state_q != ST_IDLE);

`ifdef SPI_ARB_TIMEOUT_EN
    assign abort_o = (state_q == ST_ABORT);
    assign err_o   = abort_o ? owner_oh : '0;
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_cyc_i;
    assign abort_o        = 1'b0;
    assign err_o          = '0;
`endif

endmodule

// File: tb/tb_spi_xfer_arb.sv
// Directed self-checking bench for spi_xfer_arb (default 4 requesters, 32-bit commands).
module tb_spi_xfer_arb;

    localparam int NR = 4;
    localparam int CW = 32;
    localparam int TW = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  req;
    logic [NR*CW-1:0] cmd;
    logic           ready;
    logic           done;
    logic [TW-1:0]  tmo;
    logic [NR-1:0]  gnt;
    logic [NR-1:0]  dn;
    logic [NR-1:0]  err;
    logic           xvalid;
    logic [CW-1:0]  xcmd;
    logic           abrt;
    logic [1:0]     cs;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    spi_xfer_arb #(.NUM_REQ(NR), .CMD_W(CW), .TO_W(TW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .cmd_i         (cmd),
        .gnt_o         (gnt),
        .done_o        (dn),
        .err_o         (err),
        .xfer_valid_o  (xvalid),
        .xfer_ready_i  (ready),
        .xfer_cmd_o    (xcmd),
        .xfer_done_i   (done),
        .abort_o       (abrt),
        .cs_idx_o      (cs),
        .busy_o        (busy),
        .timeout_cyc_i (tmo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [48:0] outs;
        rst = 1'b1; req = '1; ready = 1'b0; done = 1'b0; tmo = '0;
        for (int k = 0; k < NR; k++) cmd[k*CW +: CW] = 32'hDEAD_0000 + k;
        tick(); tick();
        outs = {gnt, dn, err, xvalid, abrt, busy, cs, xcmd};
        n_cmp++;
        if (outs !== 49'd0) begin
            $display("FAIL reset_outputs: got %h expected 0", outs); n_bad++;
        end
        req = '0; rst = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            $display("FAIL reset_release_idle: busy=%b gnt=%b expected 0/0000", busy, gnt); n_bad++;
        end
    endtask

    task automatic test_single();
        req = 4'b0100; cmd[2*CW +: CW] = 32'hA5A5_0001;
        #1;
        n_cmp++;
        if (gnt !== 4'b0100) begin
            $display("FAIL single_gnt: got %b expected 0100", gnt); n_bad++;
        end
        tick(); req = '0;
        n_cmp++;
        if ({xvalid, xcmd, cs, busy} !== {1'b1, 32'hA5A5_0001, 2'd2, 1'b1}) begin
            $display("FAIL single_issue: valid=%b cmd=%h cs=%0d busy=%b expected 1/a5a50001/2/1",
                     xvalid, xcmd, cs, busy); n_bad++;
        end
        ready = 1'b1;
        tick(); ready = 1'b0;
        n_cmp++;
        if (xvalid !== 1'b0 || dn !== 4'b0000) begin
            $display("FAIL single_wait: valid=%b done=%b expected 0/0000", xvalid, dn); n_bad++;
        end
        tick(); done = 1'b1;
        tick(); done = 1'b0;
        n_cmp++;
        if (dn !== 4'b0100 || cs !== 2'd2) begin
            $display("FAIL single_done_pulse: done=%b cs=%0d expected 0100/2", dn, cs); n_bad++;
        end
        tick();
        n_cmp++;
        if (dn !== 4'b0000 || busy !== 1'b0 || cs !== 2'd2) begin
            $display("FAIL single_back_idle: done=%b busy=%b cs=%0d expected 0000/0/2", dn, busy, cs); n_bad++;
        end
    endtask

    task automatic test_ignore_done();
        done = 1'b1;
        tick();
        n_cmp++;
        if (dn !== 4'b0000 || busy !== 1'b0) begin
            $display("FAIL done_in_idle: done=%b busy=%b expected 0000/0", dn, busy); n_bad++;
        end
        req = 4'b0001; cmd[0 +: CW] = 32'h5555_0000;
        tick(); req = '0;
        tick();
        n_cmp++;
        if (xvalid !== 1'b1 || dn !== 4'b0000) begin
            $display("FAIL done_in_issue: valid=%b done=%b expected 1/0000", xvalid, dn); n_bad++;
        end
        ready = 1'b1; done = 1'b0;
        tick(); ready = 1'b0; done = 1'b1;
        tick(); done = 1'b0;
        n_cmp++;
        if (dn !== 4'b0001) begin
            $display("FAIL ignore_then_done: got %b expected 0001", dn); n_bad++;
        end
        tick();
    endtask

    task automatic test_ready_stall();
        int bad;
        req = 4'b1000; cmd[3*CW +: CW] = 32'hC0DE_0003;
        #1;
        n_cmp++;
        if (gnt !== 4'b1000) begin
            $display("FAIL stall_gnt: got %b expected 1000", gnt); n_bad++;
        end
        bad = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(); req = '0;
            if (xvalid !== 1'b1 || xcmd !== 32'hC0DE_0003) bad++;
            if (i == 10) ready = 1'b1;
        end
        n_cmp++;
        if (bad != 0) begin
            $display("FAIL stall_stable: %0d unstable cycles, expected 0", bad); n_bad++;
        end
        tick(); ready = 1'b0;
        n_cmp++;
        if (xvalid !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL stall_wait_cycle11: valid=%b busy=%b expected 0/1", xvalid, busy); n_bad++;
        end
        done = 1'b1;
        tick(); done = 1'b0;
        n_cmp++;
        if (dn !== 4'b1000) begin
            $display("FAIL stall_done: got %b expected 1000", dn); n_bad++;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] exp_oh;
        int idx;
        rst = 1'b1; req = '1;
        for (int k = 0; k < NR; k++) cmd[k*CW +: CW] = 32'h1000_0000 + k;
        tick();
        rst = 1'b0;
        #1;
        for (int n = 0; n < 5; n++) begin
            idx = n % NR;
            exp_oh = 4'b0001 << idx;
            n_cmp++;
            if (gnt !== exp_oh || dn !== 4'b0000) begin
                $display("FAIL rr_gnt_%0d: gnt=%b done=%b expected %b/0000", n, gnt, dn, exp_oh); n_bad++;
            end
            tick();
            n_cmp++;
            if (cs !== 2'(idx) || xcmd !== 32'h1000_0000 + idx) begin
                $display("FAIL rr_issue_%0d: cs=%0d cmd=%h expected %0d/%h", n, cs, xcmd, idx,
                         32'h1000_0000 + idx); n_bad++;
            end
            ready = 1'b1;
            tick(); ready = 1'b0; done = 1'b1;
            tick(); done = 1'b0;
            n_cmp++;
            if (dn !== exp_oh) begin
                $display("FAIL rr_done_%0d: got %b expected %b", n, dn, exp_oh); n_bad++;
            end
            if (n == 4) req = '0;
            tick();
        end
    endtask

    task automatic test_reset_wait();
        logic [48:0] outs;
        req = 4'b0100;
        tick(); req = '0; ready = 1'b1;
        tick(); ready = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || xvalid !== 1'b0) begin
            $display("FAIL rstw_in_wait: busy=%b valid=%b expected 1/0", busy, xvalid); n_bad++;
        end
        #2;
        rst = 1'b1; done = 1'b1;
        #1;
        outs = {gnt, dn, err, xvalid, abrt, busy, cs, xcmd};
        n_cmp++;
        if (outs !== 49'd0) begin
            $display("FAIL rstw_async_clear: got %h expected 0", outs); n_bad++;
        end
        tick(); tick();
        n_cmp++;
        if (dn !== 4'b0000) begin
            $display("FAIL rstw_no_done: got %b expected 0000", dn); n_bad++;
        end
        done = 1'b0; req = '1; rst = 1'b0;
        #1;
        n_cmp++;
        if (gnt !== 4'b0001) begin
            $display("FAIL rstw_first_gnt: got %b expected 0001", gnt); n_bad++;
        end
        req = '0;
        tick(); ready = 1'b1;
        tick(); ready = 1'b0; done = 1'b1;
        tick(); done = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int bad;
        rst = 1'b1;
        tick();
        rst = 1'b0; tmo = 16'd8; req = 4'b0010;
        #1;
        n_cmp++;
        if (gnt !== 4'b0010) begin
            $display("FAIL to_gnt: got %b expected 0010", gnt); n_bad++;
        end
        tick(); req = '0; ready = 1'b1;
        tick(); ready = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (abrt !== 1'b0 || busy !== 1'b1 || dn !== 4'b0000) bad++;
            tick();
        end
        n_cmp++;
        if (bad != 0) begin
            $display("FAIL to_early_abort: %0d bad WAIT cycles, expected 0", bad); n_bad++;
        end
        n_cmp++;
        if ({abrt, err, dn} !== {1'b1, 4'b0010, 4'b0010}) begin
            $display("FAIL to_abort_pulse: abort=%b err=%b done=%b expected 1/0010/0010", abrt, err, dn);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (abrt !== 1'b0 || busy !== 1'b0 || err !== 4'b0000) begin
            $display("FAIL to_after_abort: abort=%b busy=%b err=%b expected 0/0/0000", abrt, busy, err);
            n_bad++;
        end
        tmo = 16'd0; req = 4'b0001;
        tick(); req = '0; ready = 1'b1;
        tick(); ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (abrt !== 1'b0 || busy !== 1'b1) bad++;
            tick();
        end
        n_cmp++;
        if (bad != 0) begin
            $display("FAIL to_disabled: %0d bad cycles, expected 0", bad); n_bad++;
        end
        done = 1'b1;
        tick(); done = 1'b0;
        tick();
        tmo = 16'd3; req = 4'b0001;
        tick(); req = '0; ready = 1'b1;
        tick(); ready = 1'b0;
        tick();
        tick(); done = 1'b1;
        tick(); done = 1'b0;
        n_cmp++;
        if ({abrt, err, dn} !== {1'b0, 4'b0000, 4'b0001}) begin
            $display("FAIL to_done_wins: abort=%b err=%b done=%b expected 0/0000/0001", abrt, err, dn);
            n_bad++;
        end
        tick();
`else
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (abrt !== 1'b0 || err !== 4'b0000 || busy !== 1'b1 || dn !== 4'b0000) bad++;
            tick();
        end
        n_cmp++;
        if (bad != 0) begin
            $display("FAIL no_to_wait_hold: %0d bad cycles, expected 0", bad); n_bad++;
        end
        done = 1'b1;
        tick(); done = 1'b0;
        n_cmp++;
        if (dn !== 4'b0010 || err !== 4'b0000) begin
            $display("FAIL no_to_done: done=%b err=%b expected 0010/0000", dn, err); n_bad++;
        end
        tick();
`endif
    endtask

    initial begin
        rst = 1'b1; req = '0; cmd = '0; ready = 1'b0; done = 1'b0; tmo = '0;
        test_reset();
        test_single();
        test_ignore_done();
        test_ready_stall();
        test_back_to_back();
        test_reset_wait();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
